// File: rtl/skew_feeder.sv
// Tile buffer that replays stored column vectors onto the systolic array edge
// with diagonal skew: lane i lags lane 0 by i cycles, per-lane valid marks real data.
module skew_feeder #(
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned LENGTH     = 4,
  parameter int unsigned DEPTH      = 4,
  parameter int unsigned CNT_WIDTH  = 3
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic                                in_valid,
  output logic                                in_ready,
  input  logic [0:LENGTH-1][DATA_WIDTH-1:0]   in_data,
  input  logic                                start,
  output logic [0:LENGTH-1][DATA_WIDTH-1:0]   out_data,
  output logic [0:LENGTH-1]                   out_valid,
  output logic                                busy,
  output logic                                done,
  output logic [CNT_WIDTH-1:0]                load_cnt
);

  localparam int unsigned CW = CNT_WIDTH;
  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic {
    IDLE = 1'b0,
    FEED = 1'b1
  } state_t;

  state_t                              state_q, state_d;
  logic [CW-1:0]                       t_q, t_d;
  logic [CW-1:0]                       load_cnt_d;
  logic                                wr_en;
  logic                                done_d;
  logic                                in_ready_d;
  logic [0:LENGTH-1][DATA_WIDTH-1:0]   out_data_d;
  logic [0:LENGTH-1]                   out_valid_d;
  logic [CW:0]                         k_ext;
  logic [CW-1:0]                       k;

  logic [0:LENGTH-1][DATA_WIDTH-1:0]   mem [DEPTH];

  // Tile storage; contents are don't-care after reset, so no reset on this array.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[AW'(load_cnt)] <= in_data;
    end
  end

  // State register and registered outputs.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= IDLE;
      t_q       <= '0;
      load_cnt  <= '0;
      done      <= 1'b0;
      busy      <= 1'b0;
      in_ready  <= 1'b1;
      out_data  <= '0;
      out_valid <= '0;
    end else begin
      state_q   <= state_d;
      t_q       <= t_d;
      load_cnt  <= load_cnt_d;
      done      <= done_d;
      busy      <= (state_d == FEED);
      in_ready  <= in_ready_d;
      out_data  <= out_data_d;
      out_valid <= out_valid_d;
    end
  end

  // Next state, counters, and next-cycle lane outputs.
  always_comb begin
    state_d     = state_q;
    t_d         = t_q;
    load_cnt_d  = load_cnt;
    wr_en       = 1'b0;
    done_d      = 1'b0;
    out_data_d  = '0;
    out_valid_d = '0;
    k_ext       = '0;
    k           = '0;

    case (state_q)
      IDLE: begin
        wr_en = in_valid && in_ready;
        if (wr_en) begin
          load_cnt_d = load_cnt + CW'(1);
        end
        if (start && ((load_cnt != '0) || wr_en)) begin
          state_d = FEED;
          t_d     = '0;
        end
      end
      FEED: begin
        if (t_q == (load_cnt + CW'(LENGTH) - CW'(1) - CW'(1))) begin
          state_d    = IDLE;
          t_d        = '0;
          load_cnt_d = '0;
          done_d     = 1'b1;
        end else begin
          t_d = t_q + CW'(1);
        end
      end
      default: state_d = IDLE;
    endcase

    // Lane i shows vector t-i; a vector written on the FEED-entry edge is bypassed.
    if (state_d == FEED) begin
      for (int i = 0; i < LENGTH; i++) begin
        k_ext = {1'b0, t_d} - (CW+1)'(i);
        k     = k_ext[CW-1:0];
        if (!k_ext[CW] && (k < load_cnt_d)) begin
          out_valid_d[i] = 1'b1;
          if (wr_en && (k == load_cnt)) begin
            out_data_d[i] = in_data[i];
          end else begin
            out_data_d[i] = mem[AW'(k)][i];
          end
        end
      end
    end

    in_ready_d = (state_d == IDLE) && (load_cnt_d < CW'(DEPTH));
  end

endmodule

// File: tb/tb_skew_feeder.sv
// Directed bench for skew_feeder: load/feed sequences checked against hand
// values and a per-cycle expectation of the diagonal replay.
module tb_skew_feeder;

  localparam int unsigned DW = 8;
  localparam int unsigned L  = 4;
  localparam int unsigned D  = 4;
  localparam int unsigned CW = 3;

  logic                      clk = 1'b0;
  logic                      reset;
  logic                      in_valid;
  logic                      in_ready;
  logic [0:L-1][DW-1:0]      in_data;
  logic                      start;
  logic [0:L-1][DW-1:0]      out_data;
  logic [0:L-1]              out_valid;
  logic                      busy;
  logic                      done;
  logic [CW-1:0]             load_cnt;

  int vectors = 0;
  int errs    = 0;

  logic [0:L-1][DW-1:0] tile [D];

  skew_feeder #(.DATA_WIDTH(DW), .LENGTH(L), .DEPTH(D), .CNT_WIDTH(CW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
    .in_data(in_data), .start(start), .out_data(out_data), .out_valid(out_valid),
    .busy(busy), .done(done), .load_cnt(load_cnt)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Load one vector in IDLE; also records it as the expected tile entry.
  task automatic load(input logic [0:L-1][DW-1:0] v, input int idx);
    in_valid = 1'b1;
    in_data  = v;
    tile[idx] = v;
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    chk("load_cnt_after_load", 32'(load_cnt), 32'(idx + 1));
  endtask

  // Called at FEED t=0 sample point; walks the feed and the done cycle.
  task automatic feed(input int n, input bit disturb);
    logic [0:L-1][DW-1:0] ed;
    logic [0:L-1]         ev;
    for (int t = 0; t < n + L - 1; t++) begin
      if (t > 0) tick();
      ed = '0;
      ev = '0;
      for (int i = 0; i < L; i++) begin
        if (t - i >= 0 && t - i < n) begin
          ed[i] = tile[t - i][i];
          ev[i] = 1'b1;
        end
      end
      chk($sformatf("out_data_t%0d", t), 32'(out_data), 32'(ed));
      chk($sformatf("out_valid_t%0d", t), 32'(out_valid), 32'(ev));
      chk($sformatf("busy_t%0d", t), 32'(busy), 32'd1);
      chk($sformatf("in_ready_t%0d", t), 32'(in_ready), 32'd0);
      chk($sformatf("load_cnt_t%0d", t), 32'(load_cnt), 32'(n));
      chk($sformatf("done_t%0d", t), 32'(done), 32'd0);
      if (disturb) begin
        start    = 1'b1;
        in_valid = 1'b1;
        in_data  = {8'd99, 8'd99, 8'd99, 8'd99};
      end
    end
    tick();
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = '0;
    chk("done_pulse", 32'(done), 32'd1);
    chk("done_busy", 32'(busy), 32'd0);
    chk("done_out_valid", 32'(out_valid), 32'd0);
    chk("done_load_cnt", 32'(load_cnt), 32'd0);
    chk("done_in_ready", 32'(in_ready), 32'd1);
    tick();
    chk("done_cleared", 32'(done), 32'd0);
    chk("idle_busy", 32'(busy), 32'd0);
  endtask

  initial begin
    reset    = 1'b1;
    in_valid = 1'b0;
    in_data  = '0;
    start    = 1'b0;
    repeat (2) @(posedge clk);
    #3 reset = 1'b0;
    tick();
    chk("rst_in_ready", 32'(in_ready), 32'd1);
    chk("rst_load_cnt", 32'(load_cnt), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_done", 32'(done), 32'd0);
    chk("rst_out_valid", 32'(out_valid), 32'd0);
    chk("rst_out_data", 32'(out_data), 32'd0);

    // Empty start is ignored.
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("empty_start_busy", 32'(busy), 32'd0);
    chk("empty_start_done", 32'(done), 32'd0);
    tick();
    chk("empty_start_done2", 32'(done), 32'd0);
    chk("empty_start_cnt", 32'(load_cnt), 32'd0);

    // Full tile plus overflow attempt.
    load({8'd1,  8'd2,  8'd3,  8'd4},  0);
    load({8'd5,  8'd6,  8'd7,  8'd8},  1);
    load({8'd9,  8'd10, 8'd11, 8'd12}, 2);
    load({8'd13, 8'd14, 8'd15, 8'd16}, 3);
    chk("full_in_ready", 32'(in_ready), 32'd0);
    in_valid = 1'b1;
    in_data  = {8'd99, 8'd99, 8'd99, 8'd99};
    tick();
    in_valid = 1'b0;
    in_data  = '0;
    chk("overflow_load_cnt", 32'(load_cnt), 32'd4);
    chk("overflow_in_ready", 32'(in_ready), 32'd0);
    start = 1'b1;
    tick();
    start = 1'b0;
    chk("full_t0_data_const", 32'(out_data), 32'h01000000);
    chk("full_t0_valid_const", 32'(out_valid), 32'b1000);
    feed(4, 1'b0);

    // Partial tile with write and start in the same cycle; disturb during FEED.
    load({8'd21, 8'd22, 8'd23, 8'd24}, 0);
    in_valid = 1'b1;
    start    = 1'b1;
    in_data  = {8'd31, 8'd32, 8'd33, 8'd34};
    tile[1]  = in_data;
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = '0;
    chk("partial_t0_data_const", 32'(out_data), 32'h15000000);
    feed(2, 1'b1);

    // Single vector written together with start from empty (bypass path).
    in_valid = 1'b1;
    start    = 1'b1;
    in_data  = {8'hA1, 8'hB2, 8'hC3, 8'hD4};
    tile[0]  = in_data;
    tick();
    in_valid = 1'b0;
    start    = 1'b0;
    in_data  = '0;
    chk("n1_t0_data_const", 32'(out_data), 32'hA1000000);
    feed(1, 1'b0);

    // Asynchronous reset at t=2 of FEED.
    load({8'd41, 8'd42, 8'd43, 8'd44}, 0);
    load({8'd51, 8'd52, 8'd53, 8'd54}, 1);
    load({8'd61, 8'd62, 8'd63, 8'd64}, 2);
    start = 1'b1;
    tick();
    start = 1'b0;
    tick();
    tick();
    chk("pre_reset_busy", 32'(busy), 32'd1);
    #2 reset = 1'b1;
    #1;
    chk("async_busy", 32'(busy), 32'd0);
    chk("async_out_valid", 32'(out_valid), 32'd0);
    chk("async_out_data", 32'(out_data), 32'd0);
    chk("async_load_cnt", 32'(load_cnt), 32'd0);
    chk("async_done", 32'(done), 32'd0);
    @(negedge clk);
    reset = 1'b0;
    tick();
    chk("post_reset_in_ready", 32'(in_ready), 32'd1);
    load({8'd71, 8'd72, 8'd73, 8'd74}, 0);
    load({8'd81, 8'd82, 8'd83, 8'd84}, 1);
    start = 1'b1;
    tick();
    start = 1'b0;
    feed(2, 1'b0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, errs);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout observed=running expected=finished");
    $fatal(1, "bench timeout");
  end

endmodule
